// File: rtl/ppu_pkg.sv
// Shared types and colours for the procedural Battleship board renderer.
// Cell states match the 2-bit encoding stored in the cell RAM.
package ppu_pkg;

    typedef enum logic [1:0] {
        WATER = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK      = 24'h000000;
    localparam rgb_t COL_BACKGROUND = 24'h102010;
    localparam rgb_t COL_GRID_LINE  = 24'h000000;
    localparam rgb_t COL_WATER      = 24'h1E64C8;
    localparam rgb_t COL_SHIP       = 24'h808080;
    localparam rgb_t COL_HIT        = 24'hE02020;
    localparam rgb_t COL_MISS       = 24'hFFFFFF;
    localparam rgb_t COL_CURSOR     = 24'hFFFF00;

    function automatic rgb_t cell_colour(input cell_state_t state);
        rgb_t colour;
        case (state)
            WATER:   colour = COL_WATER;
            SHIP:    colour = COL_SHIP;
            HIT:     colour = COL_HIT;
            MISS:    colour = COL_MISS;
            default: colour = COL_WATER;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Cell-write / board-clear port between game logic (master) and the renderer (slave).
interface board_renderer_if #(
    parameter int NUM_BOARDS = 2,
    localparam int BOARD_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) ();

    logic               wr_valid;
    logic               wr_ready;
    logic [BOARD_W-1:0] wr_board;
    logic [3:0]         wr_row;
    logic [3:0]         wr_col;
    logic [1:0]         wr_state;
    logic               clr_valid;
    logic               clr_busy;

    modport master (
        output wr_valid, wr_board, wr_row, wr_col, wr_state, clr_valid,
        input  wr_ready, clr_busy
    );

    modport slave (
        input  wr_valid, wr_board, wr_row, wr_col, wr_state, clr_valid,
        output wr_ready, clr_busy
    );

endinterface

// File: rtl/board_cell_ram.sv
// Per-cell state store: one synchronous read port for the pixel pipeline, one write port.
// Contents are deliberately not reset; software clears boards explicitly.
module board_cell_ram
    import ppu_pkg::*;
#(
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  cell_state_t       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output cell_state_t       rd_data
);

    cell_state_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/board_renderer.sv
// Draws NUM_BOARDS Battleship grids procedurally from a cell-state RAM, 2-cycle pixel latency.
// Optional macro BOARD_CURSOR_EN adds a 1-px highlight ring inside one selected cell.
module board_renderer
    import ppu_pkg::*;
#(
    parameter int NUM_BOARDS   = 2,
    parameter int GRID         = 10,
    parameter int CELL_PX_LOG2 = 4,
    parameter int BOARD_X0     = 100,
    parameter int BOARD_Y0     = 160,
    parameter int BOARD_GAP    = 78,
    parameter int V_ACTIVE     = 480,
    localparam int BOARD_W     = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic [9:0]         next_x,
    input  logic [9:0]         next_y,
    board_renderer_if.slave    wr_bus,
`ifdef BOARD_CURSOR_EN
    input  logic               cur_en,
    input  logic [BOARD_W-1:0] cur_board,
    input  logic [3:0]         cur_row,
    input  logic [3:0]         cur_col,
`endif
    output logic [7:0]         r_in,
    output logic [7:0]         g_in,
    output logic [7:0]         b_in
);

    localparam int PITCH    = 1 << CELL_PX_LOG2;
    localparam int BOARD_PX = GRID * PITCH + 1;
    localparam int STRIDE   = BOARD_PX + BOARD_GAP;
    localparam int CELLS    = GRID * GRID;
    localparam int DEPTH    = NUM_BOARDS * CELLS;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int CELL_W   = $clog2(CELLS);
    localparam logic [CELL_PX_LOG2-1:0] SUB_ZERO = '0;

    logic [10:0]             px, py, lx, ly, row_full, col_full;
    logic                    in_rows, hit, on_grid;
    logic [BOARD_W-1:0]      hit_board;
    logic [CELL_PX_LOG2-1:0] lx_sub, ly_sub;
    logic [ADDR_W-1:0]       rd_addr, wr_addr;
    cell_state_t             rd_data, wr_data;
    logic                    wr_en;

    // 11-bit position math so the right edge of the last board cannot wrap.
    assign px      = {1'b0, next_x};
    assign py      = {1'b0, next_y};
    assign in_rows = (py >= 11'(BOARD_Y0)) && (py < 11'(BOARD_Y0 + BOARD_PX));
    assign ly      = py - 11'(BOARD_Y0);

    always_comb begin
        hit       = 1'b0;
        hit_board = '0;
        lx        = '0;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            if (!hit && in_rows && (px >= 11'(BOARD_X0 + b * STRIDE)) &&
                (px < 11'(BOARD_X0 + b * STRIDE + BOARD_PX))) begin
                hit       = 1'b1;
                hit_board = BOARD_W'(b);
                lx        = px - 11'(BOARD_X0 + b * STRIDE);
            end
        end
    end

    assign lx_sub   = lx[CELL_PX_LOG2-1:0];
    assign ly_sub   = ly[CELL_PX_LOG2-1:0];
    assign on_grid  = (lx_sub == SUB_ZERO) || (ly_sub == SUB_ZERO);
    assign col_full = lx >> CELL_PX_LOG2;
    assign row_full = ly >> CELL_PX_LOG2;

    // The closing line yields row/col == GRID; it is always a grid pixel, so the address is parked.
    assign rd_addr = (hit && !on_grid)
                   ? ADDR_W'((int'(hit_board) * GRID + int'(row_full)) * GRID + int'(col_full))
                   : '0;

`ifdef BOARD_CURSOR_EN
    localparam logic [CELL_PX_LOG2-1:0] SUB_ONE  = CELL_PX_LOG2'(1);
    localparam logic [CELL_PX_LOG2-1:0] SUB_LAST = CELL_PX_LOG2'(PITCH - 1);
    logic cur_ring;
    assign cur_ring = cur_en && hit && (hit_board == cur_board) &&
                      (row_full == 11'(cur_row)) && (col_full == 11'(cur_col)) &&
                      ((lx_sub == SUB_ONE) || (lx_sub == SUB_LAST) ||
                       (ly_sub == SUB_ONE) || (ly_sub == SUB_LAST));
`endif

    logic s1_valid, s1_hit, s1_grid;
`ifdef BOARD_CURSOR_EN
    logic s1_cursor;
`endif
    rgb_t rgb_q;

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_hit    <= 1'b0;
            s1_grid   <= 1'b0;
`ifdef BOARD_CURSOR_EN
            s1_cursor <= 1'b0;
`endif
        end else begin
            s1_valid  <= 1'b1;
            s1_hit    <= hit;
            s1_grid   <= on_grid;
`ifdef BOARD_CURSOR_EN
            s1_cursor <= cur_ring;
`endif
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            rgb_q <= COL_BLACK;
        end else if (!s1_valid) begin
            rgb_q <= COL_BLACK;
        end else if (!s1_hit) begin
            rgb_q <= COL_BACKGROUND;
        end else if (s1_grid) begin
            rgb_q <= COL_GRID_LINE;
`ifdef BOARD_CURSOR_EN
        end else if (s1_cursor) begin
            rgb_q <= COL_CURSOR;
`endif
        end else begin
            rgb_q <= cell_colour(rd_data);
        end
    end

    assign r_in = rgb_q.r;
    assign g_in = rgb_q.g;
    assign b_in = rgb_q.b;

    clr_state_t         state;
    logic [BOARD_W-1:0] clr_board;
    logic [CELL_W-1:0]  clr_cell;
    logic               clr_busy_q, ready_q, in_vblank;
    logic               usr_in_range, usr_we, clr_we;

    assign in_vblank = (next_y >= 10'(V_ACTIVE));

    // ready_q already encodes "vblank and idle"; a same-cycle clear request still takes priority.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_board  <= '0;
            clr_cell   <= '0;
            clr_busy_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_bus.clr_valid) begin
                        state      <= CLEAR;
                        clr_board  <= wr_bus.wr_board;
                        clr_cell   <= '0;
                        clr_busy_q <= 1'b1;
                        ready_q    <= 1'b0;
                    end else begin
                        ready_q    <= in_vblank;
                    end
                end
                CLEAR: begin
                    ready_q <= 1'b0;
                    if (in_vblank) begin
                        if (clr_cell == CELL_W'(CELLS - 1)) begin
                            state      <= IDLE;
                            clr_busy_q <= 1'b0;
                            ready_q    <= 1'b1;
                        end else begin
                            clr_cell <= clr_cell + CELL_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_bus.wr_ready = ready_q && !wr_bus.clr_valid;
    assign wr_bus.clr_busy = clr_busy_q;

    assign usr_in_range = (int'(wr_bus.wr_board) < NUM_BOARDS) &&
                          (int'(wr_bus.wr_row) < GRID) && (int'(wr_bus.wr_col) < GRID);
    assign usr_we  = wr_bus.wr_valid && wr_bus.wr_ready && usr_in_range;
    assign clr_we  = (state == CLEAR) && in_vblank && (int'(clr_board) < NUM_BOARDS);

    assign wr_en   = usr_we || clr_we;
    assign wr_addr = clr_we
                   ? ADDR_W'(int'(clr_board) * CELLS + int'(clr_cell))
                   : ADDR_W'((int'(wr_bus.wr_board) * GRID + int'(wr_bus.wr_row)) * GRID +
                             int'(wr_bus.wr_col));
    assign wr_data = clr_we ? WATER : cell_state_t'(wr_bus.wr_state);

    board_cell_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (vga_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_board_renderer.sv
// Randomised self-checking bench for board_renderer against a pixel-level model of the boards.
// Define BOARD_CURSOR_EN for both bench and RTL to exercise the cursor ring.
module tb_board_renderer;

    localparam int NB     = 2;
    localparam int GRID   = 10;
    localparam int PITCH  = 16;
    localparam int BPX    = 161;
    localparam int X0     = 100;
    localparam int Y0     = 160;
    localparam int STRIDE = 239;

    logic       vga_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [9:0] next_x  = '0;
    logic [9:0] next_y  = '0;
    logic [7:0] r_in, g_in, b_in;

    board_renderer_if #(.NUM_BOARDS(NB)) bus ();

`ifdef BOARD_CURSOR_EN
    logic       cur_en    = 1'b0;
    logic [0:0] cur_board = '0;
    logic [3:0] cur_row   = '0;
    logic [3:0] cur_col   = '0;
`endif

    board_renderer #(.NUM_BOARDS(NB)) dut (
        .vga_clk   (vga_clk),
        .rst_n     (rst_n),
        .next_x    (next_x),
        .next_y    (next_y),
        .wr_bus    (bus),
`ifdef BOARD_CURSOR_EN
        .cur_en    (cur_en),
        .cur_board (cur_board),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
`endif
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in)
    );

    always #20 vga_clk = ~vga_clk;

    int cells [NB][GRID][GRID];
    int tests = 0;
    int fails = 0;

    function automatic logic [23:0] model_rgb(input int x, input int y);
        for (int b = 0; b < NB; b++) begin
            int ox = X0 + b * STRIDE;
            if (x >= ox && x < ox + BPX && y >= Y0 && y < Y0 + BPX) begin
                int lx = x - ox;
                int ly = y - Y0;
                if (lx % PITCH == 0 || ly % PITCH == 0) return 24'h000000;
`ifdef BOARD_CURSOR_EN
                if (cur_en && b == int'(cur_board) && ly / PITCH == int'(cur_row) &&
                    lx / PITCH == int'(cur_col) &&
                    (lx % PITCH == 1 || lx % PITCH == PITCH - 1 ||
                     ly % PITCH == 1 || ly % PITCH == PITCH - 1))
                    return 24'hFFFF00;
`endif
                case (cells[b][ly / PITCH][lx / PITCH])
                    0:       return 24'h1E64C8;
                    1:       return 24'h808080;
                    2:       return 24'hE02020;
                    default: return 24'hFFFFFF;
                endcase
            end
        end
        return 24'h102010;
    endfunction

    task automatic get_pixel(input int x, input int y, output logic [23:0] rgb);
        @(negedge vga_clk);
        next_x = 10'(x);
        next_y = 10'(y);
        @(posedge vga_clk);
        @(posedge vga_clk);
        @(negedge vga_clk);
        rgb = {r_in, g_in, b_in};
    endtask

    task automatic do_write(input int b, input int r, input int c, input int s, output bit acc);
        acc = 1'b0;
        @(negedge vga_clk);
        bus.wr_board = 1'(b);
        bus.wr_row   = 4'(r);
        bus.wr_col   = 4'(c);
        bus.wr_state = 2'(s);
        bus.wr_valid = 1'b1;
        next_y       = 10'd480;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge vga_clk);
            if (bus.wr_ready) begin
                acc = 1'b1;
                @(posedge vga_clk);
            end
        end
        @(negedge vga_clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_clear(input int b);
        int n = 0;
        @(negedge vga_clk);
        bus.wr_board  = 1'(b);
        bus.clr_valid = 1'b1;
        next_y        = 10'd480;
        @(negedge vga_clk);
        bus.clr_valid = 1'b0;
        while (bus.clr_busy && n < 300) begin
            @(negedge vga_clk);
            n++;
        end
        tests++;
        if (bus.clr_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clear_done board %0d: clr_busy=%b after %0d cycles, want 0", b, bus.clr_busy, n);
        end
        for (int r = 0; r < GRID; r++)
            for (int c = 0; c < GRID; c++)
                cells[b][r][c] = 0;
    endtask

    task automatic test_reset();
        logic [23:0] got;
        @(posedge vga_clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge vga_clk);
            tests++;
            if ({r_in, g_in, b_in} !== 24'h0 || bus.wr_ready !== 1'b0 || bus.clr_busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_outputs: rgb=%h rdy=%b busy=%b, want 000000/0/0",
                         {r_in, g_in, b_in}, bus.wr_ready, bus.clr_busy);
            end
            next_x = 10'($urandom_range(0, 639));
            next_y = 10'($urandom_range(0, 524));
        end
        @(negedge vga_clk);
        rst_n  = 1'b1;
        next_x = 10'd99;
        next_y = 10'd200;
        @(negedge vga_clk);
        got = {r_in, g_in, b_in};
        tests++;
        if (got !== 24'h000000) begin
            fails++;
            $display("[TB] FAIL reset_latency_1: rgb=%h, want 000000", got);
        end
        @(negedge vga_clk);
        got = {r_in, g_in, b_in};
        tests++;
        if (got !== 24'h102010) begin
            fails++;
            $display("[TB] FAIL reset_latency_2: rgb=%h, want 102010", got);
        end
    endtask

    task automatic test_basic_write();
        logic [23:0] got;
        bit acc;
        int px [6] = '{169, 164, 99, 260, 261, 105};
        int py [6] = '{213, 208, 200, 200, 200, 165};
        do_clear(0);
        do_clear(1);
        do_write(0, 3, 4, 2, acc);
        tests++;
        if (!acc) begin
            fails++;
            $display("[TB] FAIL basic_write_accept: accepted=%b, want 1", acc);
        end else begin
            cells[0][3][4] = 2;
        end
        for (int i = 0; i < 6; i++) begin
            get_pixel(px[i], py[i], got);
            tests++;
            if (got !== model_rgb(px[i], py[i])) begin
                fails++;
                $display("[TB] FAIL basic_pixel (%0d,%0d): rgb=%h, want %h", px[i], py[i], got, model_rgb(px[i], py[i]));
            end
        end
        get_pixel(169, 213, got);
        tests++;
        if (got !== 24'hE02020) begin
            fails++;
            $display("[TB] FAIL hit_colour: rgb=%h, want E02020", got);
        end
    endtask

    task automatic test_vblank_gating();
        logic [23:0] got;
        int bad = 0;
        bit acc = 1'b0;
        @(negedge vga_clk);
        bus.wr_board = 1'b0;
        bus.wr_row   = 4'd5;
        bus.wr_col   = 4'd5;
        bus.wr_state = 2'd1;
        bus.wr_valid = 1'b1;
        next_y       = 10'd100;
        for (int i = 0; i < 20; i++) begin
            @(negedge vga_clk);
            if (bus.wr_ready !== 1'b0) bad++;
            next_y = 10'(100 + i * 10);
        end
        get_pixel(185, 245, got);
        tests++;
        if (got !== 24'h1E64C8) begin
            fails++;
            $display("[TB] FAIL gated_old_colour: rgb=%h, want 1E64C8", got);
        end
        next_y = 10'd479;
        @(negedge vga_clk);
        if (bus.wr_ready !== 1'b0) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL ready_in_active: %0d cycles with wr_ready=1, want 0", bad);
        end
        next_y = 10'd480;
        for (int i = 0; i < 5 && !acc; i++) begin
            @(negedge vga_clk);
            if (bus.wr_ready) begin
                acc = 1'b1;
                @(posedge vga_clk);
            end
        end
        @(negedge vga_clk);
        bus.wr_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("[TB] FAIL ready_in_vblank: accepted=%b, want 1", acc);
        end else begin
            cells[0][5][5] = 1;
        end
        get_pixel(185, 245, got);
        tests++;
        if (got !== 24'h808080) begin
            fails++;
            $display("[TB] FAIL gated_new_colour: rgb=%h, want 808080", got);
        end
    endtask

    task automatic test_clear_pause();
        logic [23:0] got;
        bit acc;
        int vb = 0, n = 0;
        bit done = 1'b0;
        do_write(1, 0, 0, 1, acc);
        if (acc) cells[1][0][0] = 1;
        do_write(1, 9, 9, 3, acc);
        if (acc) cells[1][9][9] = 3;
        @(negedge vga_clk);
        next_y        = 10'd478;
        bus.wr_board  = 1'b1;
        bus.clr_valid = 1'b1;
        @(negedge vga_clk);
        bus.clr_valid = 1'b0;
        next_y        = 10'd479;
        tests++;
        if (bus.clr_busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clear_busy_start: clr_busy=%b, want 1", bus.clr_busy);
        end
        while (!done && n < 400) begin
            @(negedge vga_clk);
            if (!bus.clr_busy) begin
                done = 1'b1;
            end else begin
                if (n < 40 || n >= 60) begin
                    next_y = 10'(480 + n % 40);
                    vb++;
                end else begin
                    next_y = 10'(100 + n);
                end
                n++;
            end
        end
        tests++;
        if (!done || vb != 100) begin
            fails++;
            $display("[TB] FAIL clear_vblank_cycles: done=%b vblank_cycles=%0d, want 1/100", done, vb);
        end
        for (int r = 0; r < GRID; r++)
            for (int c = 0; c < GRID; c++)
                cells[1][r][c] = 0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                get_pixel(X0 + STRIDE + c * PITCH + 7, Y0 + r * PITCH + 9, got);
                tests++;
                if (got !== 24'h1E64C8) begin
                    fails++;
                    $display("[TB] FAIL cleared_cell b1 r%0d c%0d: rgb=%h, want 1E64C8", r, c, got);
                end
            end
        end
    endtask

    task automatic test_write_clear_collision();
        logic [23:0] got;
        int n = 0, bad = 0;
        bit acc = 1'b0;
        @(negedge vga_clk);
        next_y = 10'd480;
        @(negedge vga_clk);
        bus.wr_board  = 1'b0;
        bus.wr_row    = 4'd7;
        bus.wr_col    = 4'd2;
        bus.wr_state  = 2'd3;
        bus.wr_valid  = 1'b1;
        bus.clr_valid = 1'b1;
        #1;
        tests++;
        if (bus.wr_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL collision_ready: wr_ready=%b, want 0", bus.wr_ready);
        end
        @(negedge vga_clk);
        bus.clr_valid = 1'b0;
        while (bus.clr_busy && n < 300) begin
            if (bus.wr_ready !== 1'b0) bad++;
            @(negedge vga_clk);
            n++;
        end
        tests++;
        if (bus.clr_busy !== 1'b0 || bad != 0 || n == 0) begin
            fails++;
            $display("[TB] FAIL collision_clear: busy=%b ready_during_clear=%0d cycles=%0d, want 0/0/>0", bus.clr_busy, bad, n);
        end
        for (int r = 0; r < GRID; r++)
            for (int c = 0; c < GRID; c++)
                cells[0][r][c] = 0;
        for (int i = 0; i < 5 && !acc; i++) begin
            if (bus.wr_ready) begin
                acc = 1'b1;
                @(posedge vga_clk);
            end
            @(negedge vga_clk);
        end
        bus.wr_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("[TB] FAIL collision_write_after: accepted=%b, want 1", acc);
        end else begin
            cells[0][7][2] = 3;
        end
        get_pixel(X0 + 2 * PITCH + 5, Y0 + 7 * PITCH + 5, got);
        tests++;
        if (got !== 24'hFFFFFF) begin
            fails++;
            $display("[TB] FAIL collision_written: rgb=%h, want FFFFFF", got);
        end
        get_pixel(X0 + 4 * PITCH + 5, Y0 + 3 * PITCH + 5, got);
        tests++;
        if (got !== 24'h1E64C8) begin
            fails++;
            $display("[TB] FAIL collision_cleared: rgb=%h, want 1E64C8", got);
        end
    endtask

    task automatic test_out_of_range();
        logic [23:0] got;
        bit acc;
        do_write(0, 12, 3, 2, acc);
        tests++;
        if (!acc) begin
            fails++;
            $display("[TB] FAIL oob_row_accept: accepted=%b, want 1", acc);
        end
        do_write(0, 3, 11, 2, acc);
        tests++;
        if (!acc) begin
            fails++;
            $display("[TB] FAIL oob_col_accept: accepted=%b, want 1", acc);
        end
        get_pixel(X0 + STRIDE + 3 * PITCH + 5, Y0 + 2 * PITCH + 5, got);
        tests++;
        if (got !== model_rgb(X0 + STRIDE + 3 * PITCH + 5, Y0 + 2 * PITCH + 5)) begin
            fails++;
            $display("[TB] FAIL oob_row_dropped: rgb=%h, want %h", got,
                     model_rgb(X0 + STRIDE + 3 * PITCH + 5, Y0 + 2 * PITCH + 5));
        end
        get_pixel(X0 + 1 * PITCH + 5, Y0 + 4 * PITCH + 5, got);
        tests++;
        if (got !== model_rgb(X0 + 1 * PITCH + 5, Y0 + 4 * PITCH + 5)) begin
            fails++;
            $display("[TB] FAIL oob_col_dropped: rgb=%h, want %h", got,
                     model_rgb(X0 + 1 * PITCH + 5, Y0 + 4 * PITCH + 5));
        end
    endtask

    task automatic test_random_pixels();
        logic [23:0] expq [$];
        logic [23:0] want;
        bit acc;
        int x, y;
        for (int i = 0; i < 12; i++) begin
            int b = $urandom_range(0, NB - 1);
            int r = $urandom_range(0, GRID - 1);
            int c = $urandom_range(0, GRID - 1);
            int s = $urandom_range(0, 3);
            do_write(b, r, c, s, acc);
            tests++;
            if (!acc) begin
                fails++;
                $display("[TB] FAIL random_write_accept %0d: accepted=%b, want 1", i, acc);
            end else begin
                cells[b][r][c] = s;
            end
        end
        for (int i = 0; i < 302; i++) begin
            @(negedge vga_clk);
            if (expq.size() == 2) begin
                want = expq.pop_front();
                tests++;
                if ({r_in, g_in, b_in} !== want) begin
                    fails++;
                    $display("[TB] FAIL random_pixel %0d: rgb=%h, want %h", i, {r_in, g_in, b_in}, want);
                end
            end
            if (i < 300) begin
                x = $urandom_range(80, 620);
                y = $urandom_range(150, 330);
                next_x = 10'(x);
                next_y = 10'(y);
                expq.push_back(model_rgb(x, y));
            end
        end
    endtask

`ifdef BOARD_CURSOR_EN
    task automatic test_cursor();
        logic [23:0] got;
        @(negedge vga_clk);
        cur_en    = 1'b1;
        cur_board = 1'b1;
        cur_row   = 4'd0;
        cur_col   = 4'd0;
        get_pixel(340, 165, got);
        tests++;
        if (got !== 24'hFFFF00) begin
            fails++;
            $display("[TB] FAIL cursor_ring: rgb=%h, want FFFF00", got);
        end
        get_pixel(344, 165, got);
        tests++;
        if (got !== model_rgb(344, 165)) begin
            fails++;
            $display("[TB] FAIL cursor_inside: rgb=%h, want %h", got, model_rgb(344, 165));
        end
        cur_en = 1'b0;
    endtask
`endif

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_board  = '0;
        bus.wr_row    = '0;
        bus.wr_col    = '0;
        bus.wr_state  = '0;
        bus.clr_valid = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < GRID; r++)
                for (int c = 0; c < GRID; c++)
                    cells[b][r][c] = 0;
        test_reset();
        test_basic_write();
        test_vblank_gating();
        test_clear_pause();
        test_write_clear_collision();
        test_out_of_range();
        test_random_pixels();
`ifdef BOARD_CURSOR_EN
        test_cursor();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "[TB] watchdog");
    end

endmodule
